// File: rtl/mux_pkg.sv
// Shared constants and mode encoding for the N-way registered selector.
package mux_pkg;
  localparam int DATA_W   = 16;
  localparam int WAYS_DEF = 8;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after 'last', wrapping modulo WAYS.
module rr_arbiter #(
  parameter  int WAYS  = 8,
  localparam int SEL_W = $clog2(WAYS)
) (
  input  logic [WAYS-1:0]  req,
  input  logic [SEL_W-1:0] last,
  output logic             gnt_valid,
  output logic [SEL_W-1:0] gnt_idx
);
  always_comb begin
    int s;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    s         = 0;
    // Scan last+1 .. last+WAYS; explicit wrap keeps non-power-of-two WAYS in range.
    for (int k = 1; k <= WAYS; k++) begin
      s = int'(last) + k;
      if (s >= WAYS) s = s - WAYS;
      if (!gnt_valid && req[s]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SEL_W'(s);
      end
    end
  end
endmodule

// File: rtl/mux_arb_nway.sv
// Registered N-way selector: fixed-select or round-robin grant into one output register.
module mux_arb_nway
  import mux_pkg::*;
#(
  parameter  int WIDTH = DATA_W,
  parameter  int WAYS  = WAYS_DEF,
  localparam int SEL_W = $clog2(WAYS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [WAYS-1:0]       in_valid,
  input  logic [WAYS*WIDTH-1:0] in_data,
  output logic [WAYS-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_sel,
  input  logic                  out_ready
);
  logic [WAYS-1:0][WIDTH-1:0] way_data;
  logic [SEL_W-1:0]           last;
  logic                       rr_valid, gnt_valid, load_en, xfer, sel_ok;
  logic [SEL_W-1:0]           rr_idx, gnt_idx;

  assign way_data = in_data;
  assign load_en  = !out_valid || out_ready;

  rr_arbiter #(.WAYS(WAYS)) u_rr (
    .req       (in_valid),
    .last      (last),
    .gnt_valid (rr_valid),
    .gnt_idx   (rr_idx)
  );

  assign sel_ok = (32'(sel) < WAYS);

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    if (mode_e'(mode) == MODE_RR) begin
      gnt_valid = rr_valid;
      gnt_idx   = rr_idx;
    end else if (sel_ok) begin
      gnt_valid = in_valid[sel];
      gnt_idx   = sel;
    end
  end

  for (genvar i = 0; i < WAYS; i++) begin : g_rdy
    assign in_ready[i] = rst_n && load_en && gnt_valid && (gnt_idx == SEL_W'(i));
  end

  assign xfer = |in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      last      <= SEL_W'(WAYS - 1);
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= way_data[gnt_idx];
      out_sel   <= gnt_idx;
      // Only round-robin grants advance fairness state.
      if (mode_e'(mode) == MODE_RR) last <= gnt_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mux_arb_nway.sv
// Directed bench with expected-word queue and decoupled output monitor.
module tb_mux_arb_nway;
  localparam int WIDTH = 16;
  localparam int WAYS  = 8;
  localparam int SEL_W = 3;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  mode;
  logic [SEL_W-1:0]      sel;
  logic [WAYS-1:0]       in_valid;
  logic [WAYS*WIDTH-1:0] in_data;
  logic [WAYS-1:0]       in_ready;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic [SEL_W-1:0]      out_sel;
  logic                  out_ready;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic [SEL_W-1:0] s;
  } exp_t;
  exp_t q[$];

  int errors = 0;
  int checks = 0;

  mux_arb_nway #(.WIDTH(WIDTH), .WAYS(WAYS)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int way);
    exp_t e;
    e.d = 16'h1000 + 16'(way);
    e.s = SEL_W'(way);
    q.push_back(e);
  endtask

  // Monitor: a word is consumed at the next edge whenever valid and ready are both high.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got data=%0h sel=%0d expected none", out_data, out_sel);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("out_data", 32'(out_data), 32'(e.d));
          chk("out_sel", 32'(out_sel), 32'(e.s));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; mode = 1'b0; sel = '0; out_ready = 1'b1;
    in_valid = '1;
    for (int i = 0; i < WAYS; i++) in_data[i*WIDTH +: WIDTH] = 16'h1000 + 16'(i);
    #12;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_sel", 32'(out_sel), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    step();
    rst_n = 1'b1;
    #1;

    // Fixed-mode sweep
    for (int i = 0; i < WAYS; i++) begin
      sel = SEL_W'(i);
      #1;
      chk("fix_in_ready", 32'(in_ready), 32'(1) << i);
      push(i);
      step();
    end
    in_valid = '0;
    step(); step();

    // Selected way invalid: nothing granted
    sel = 3'd3; in_valid = 8'b1111_0111;
    #1;
    chk("fix_inv_ready", 32'(in_ready), 0);
    step();
    chk("fix_inv_valid", 32'(out_valid), 0);
    in_valid[3] = 1'b1;
    push(3);
    step();
    in_valid = '0;
    step(); step();

    // Round-robin fairness, pointer still at reset value
    mode = 1'b1; in_valid = 8'b1010_0101;
    for (int r = 0; r < 2; r++) begin
      push(0); step(); push(2); step(); push(5); step(); push(7); step();
    end
    in_valid = '0;
    step(); step();

    // Backpressure after a fresh reset
    @(posedge clk); #2; rst_n = 1'b0; #2; rst_n = 1'b1;
    step();
    in_valid = '1; out_ready = 1'b1;
    push(0);
    step();
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_out_data", 32'(out_data), 32'h1000);
      chk("bp_out_valid", 32'(out_valid), 1);
      step();
    end
    out_ready = 1'b1;
    push(1);
    step();
    in_valid = '0;
    step(); step();

    // Async reset while stalled discards the held word
    in_valid = '1; out_ready = 1'b0;
    push(2);
    step();
    in_valid = '0;
    #1;
    chk("stall_valid", 32'(out_valid), 1);
    void'(q.pop_back());
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_out_data", 32'(out_data), 0);
    #1;
    rst_n = 1'b1;
    step();
    out_ready = 1'b1; in_valid = '1;
    push(0);
    step();
    in_valid = '0;
    step(); step();

    // Mode switch: pointer at 4, fixed pick 6, then RR resumes from 5
    in_valid = 8'b0001_0000;
    push(4);
    step();
    mode = 1'b0; sel = 3'd6; in_valid = '1;
    push(6);
    step();
    mode = 1'b1;
    push(5);
    step();
    in_valid = '0;

    for (int c = 0; c < 20 && q.size() != 0; c++) step();
    chk("queue_drained", 32'(q.size()), 0);
    step();
    chk("final_idle", 32'(out_valid), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
